l2_port_arbiter: RTL and testbench

- Shares the single L2-cache port between the L1 instruction cache (fetch stage) and the L1 data cache (mem stage) of the pipelined LC-3b.
- Registered FSM with round-robin fairness. Latches the winner's address and write data, then routes the L2 response back to the granted requester only.
- Sits between the split L1 caches and the L2 cache.

---
 rtl/l2_port_arbiter.sv | 98 +++++++++
 tb/tb_l2_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 port between the L1 icache and dcache.
// The winner's address and write line are latched on grant, and the L2 response is routed back to that side only.
module l2_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} state_t;

  state_t                state, state_next;
  logic                  last_d;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  req_i, req_d;
  logic                  grant_i, grant_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // on a tie the side that did not win last time goes first
        if (req_i && (!req_d || last_d)) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end else if (req_d) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end
      end
      SERVE_I: if (l2_resp) state_next = RECOVER;
      SERVE_D: if (l2_resp) state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        addr_q  <= i_address;
        write_q <= 1'b0;
        last_d  <= 1'b0;
      end
      if (grant_d) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        write_q <= d_write;
        last_d  <= 1'b1;
      end
    end
  end

  // L2 strobes depend only on registered state, never on live requester inputs
  assign l2_read    = (state == SERVE_I) || ((state == SERVE_D) && !write_q);
  assign l2_write   = (state == SERVE_D) && write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;
  assign i_resp  = (state == SERVE_I) && l2_resp;
  assign d_resp  = (state == SERVE_D) && l2_resp;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of round-robin grant order and response routing.
module tb_l2_port_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  l2_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    rst();
    i_read = 1; i_address = 16'h5555; reset = 1;
    tick();
    n_checks++; if (l2_read !== 1'b0) begin n_fail++; $display("FAIL reset_l2_read got=%b exp=0", l2_read); end
    n_checks++; if (l2_write !== 1'b0) begin n_fail++; $display("FAIL reset_l2_write got=%b exp=0", l2_write); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (l2_address !== '0) begin n_fail++; $display("FAIL reset_l2_address got=%h exp=0", l2_address); end
    n_checks++; if (l2_wdata !== '0) begin n_fail++; $display("FAIL reset_l2_wdata got=%h exp=0", l2_wdata); end
    n_checks++; if ({i_resp, d_resp} !== 2'b00) begin n_fail++; $display("FAIL reset_resp got=%b exp=00", {i_resp, d_resp}); end
    i_read = 0; reset = 0;
    tick();
  endtask

  task automatic test_icache_read();
    logic [LW-1:0] rd;
    rd = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    rst();
    i_read = 1; i_address = 16'h1230;
    tick();
    n_checks++; if (l2_read !== 1'b1) begin n_fail++; $display("FAIL iread_l2_read got=%b exp=1", l2_read); end
    n_checks++; if (l2_write !== 1'b0) begin n_fail++; $display("FAIL iread_l2_write got=%b exp=0", l2_write); end
    n_checks++; if (l2_address !== 16'h1230) begin n_fail++; $display("FAIL iread_addr got=%h exp=1230", l2_address); end
    repeat (3) begin
      tick();
      n_checks++; if ({l2_read, i_resp} !== 2'b10) begin n_fail++; $display("FAIL iread_hold got=%b exp=10", {l2_read, i_resp}); end
    end
    l2_rdata = rd; l2_resp = 1;
    #1;
    n_checks++; if (i_resp !== 1'b1) begin n_fail++; $display("FAIL iread_i_resp got=%b exp=1", i_resp); end
    n_checks++; if (i_rdata !== rd) begin n_fail++; $display("FAIL iread_i_rdata got=%h exp=%h", i_rdata, rd); end
    n_checks++; if (d_resp !== 1'b0) begin n_fail++; $display("FAIL iread_d_resp got=%b exp=0", d_resp); end
    tick();
    l2_resp = 0; i_read = 0;
    #1;
    n_checks++; if ({i_resp, l2_read, busy} !== 3'b001) begin n_fail++; $display("FAIL iread_recover got=%b exp=001", {i_resp, l2_read, busy}); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL iread_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_dcache_write();
    logic [LW-1:0] wd;
    wd = {16{8'hA5}};
    rst();
    d_write = 1; d_address = 16'h8000; d_wdata = wd;
    tick();
    d_wdata = '0;
    repeat (3) begin
      n_checks++; if ({l2_write, l2_read} !== 2'b10) begin n_fail++; $display("FAIL dwr_strobes got=%b exp=10", {l2_write, l2_read}); end
      n_checks++; if (l2_wdata !== wd) begin n_fail++; $display("FAIL dwr_wdata got=%h exp=%h", l2_wdata, wd); end
      n_checks++; if (l2_address !== 16'h8000) begin n_fail++; $display("FAIL dwr_addr got=%h exp=8000", l2_address); end
      tick();
    end
    l2_resp = 1;
    #1;
    n_checks++; if ({d_resp, i_resp} !== 2'b10) begin n_fail++; $display("FAIL dwr_resp got=%b exp=10", {d_resp, i_resp}); end
    tick();
    l2_resp = 0; d_write = 0;
    #1;
    n_checks++; if ({busy, l2_write, d_resp} !== 3'b100) begin n_fail++; $display("FAIL dwr_recover got=%b exp=100", {busy, l2_write, d_resp}); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dwr_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_alternation();
    logic exp_d;
    rst();
    i_read = 1; d_read = 1; i_address = 16'h1000; d_address = 16'h2000;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2) == 1;
      tick();
      n_checks++; if (l2_address !== (exp_d ? 16'h2000 : 16'h1000)) begin n_fail++; $display("FAIL alt_grant%0d addr got=%h exp=%h", k, l2_address, exp_d ? 16'h2000 : 16'h1000); end
      tick();
      l2_resp = 1;
      #1;
      n_checks++; if ({i_resp, d_resp} !== {!exp_d, exp_d}) begin n_fail++; $display("FAIL alt_resp%0d got=%b exp=%b", k, {i_resp, d_resp}, {!exp_d, exp_d}); end
      tick();
      l2_resp = 0;
      tick();
    end
    i_read = 0; d_read = 0;
    tick();
    tick();
  endtask

  task automatic test_addr_stable();
    rst();
    d_read = 1; d_address = 16'h0040;
    tick();
    d_address = 16'h0080;
    repeat (3) begin
      tick();
      n_checks++; if (l2_address !== 16'h0040) begin n_fail++; $display("FAIL stable_addr got=%h exp=0040", l2_address); end
    end
    l2_resp = 1;
    #1;
    n_checks++; if ({d_resp, l2_address} !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL stable_resp got=%b/%h exp=1/0040", d_resp, l2_address); end
    tick();
    l2_resp = 0; d_read = 0;
    tick();
  endtask

  task automatic test_reset_mid_serve();
    rst();
    i_read = 1; i_address = 16'h1230;
    tick();
    tick();
    reset = 1; i_read = 0;
    tick();
    n_checks++; if ({l2_read, busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_state got=%b exp=00", {l2_read, busy}); end
    reset = 0; l2_resp = 1; l2_rdata = rand_line();
    #1;
    n_checks++; if ({i_resp, d_resp} !== 2'b00) begin n_fail++; $display("FAIL midrst_stale_resp got=%b exp=00", {i_resp, d_resp}); end
    tick();
    l2_resp = 0;
    n_checks++; if ({busy, l2_read, l2_write} !== 3'b000) begin n_fail++; $display("FAIL midrst_after got=%b exp=000", {busy, l2_read, l2_write}); end
  endtask

  task automatic test_rw_conflict();
    rst();
    d_read = 1; d_write = 1; d_address = 16'h0300; d_wdata = {4{32'h1234_5678}};
    tick();
    n_checks++; if ({l2_write, l2_read} !== 2'b10) begin n_fail++; $display("FAIL rwc_strobes got=%b exp=10", {l2_write, l2_read}); end
    l2_resp = 1;
    #1;
    n_checks++; if (d_resp !== 1'b1) begin n_fail++; $display("FAIL rwc_resp got=%b exp=1", d_resp); end
    tick();
    l2_resp = 0; d_read = 0; d_write = 0;
    tick();
  endtask

  // Model: a tie is won by whichever side was not granted last; reset leaves D as last.
  task automatic test_random();
    bit pend_i, pend_d, win_d, exp_wr, mlast_d;
    int unsigned dkind;
    logic [AW-1:0] ia, da, exp_addr;
    logic [LW-1:0] dw, rd;
    rst();
    pend_i = 0; pend_d = 0; mlast_d = 1; dkind = 0;
    ia = '0; da = '0; dw = '0;
    for (int it = 0; it < 80; it++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin pend_i = 1; ia = AW'($urandom); end
      if (!pend_d && $urandom_range(0, 1) == 1) begin
        pend_d = 1; dkind = $urandom_range(0, 2); da = AW'($urandom); dw = rand_line();
      end
      if (!pend_i && !pend_d) begin
        tick();
        n_checks++; if ({busy, l2_read, l2_write} !== 3'b000) begin n_fail++; $display("FAIL rnd_idle it=%0d got=%b exp=000", it, {busy, l2_read, l2_write}); end
        pend_i = 1; ia = AW'($urandom);
      end
      i_read = pend_i; i_address = ia;
      d_read = pend_d && dkind != 1; d_write = pend_d && dkind != 0;
      d_address = da; d_wdata = dw;
      win_d = pend_d && (!pend_i || !mlast_d);
      exp_wr = win_d && dkind != 0;
      exp_addr = win_d ? da : ia;
      tick();
      n_checks++; if ({l2_read, l2_write} !== {!exp_wr, exp_wr}) begin n_fail++; $display("FAIL rnd_strobes it=%0d got=%b exp=%b", it, {l2_read, l2_write}, {!exp_wr, exp_wr}); end
      n_checks++; if (l2_address !== exp_addr) begin n_fail++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, l2_address, exp_addr); end
      if (exp_wr) begin
        n_checks++; if (l2_wdata !== dw) begin n_fail++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", it, l2_wdata, dw); end
      end
      repeat ($urandom_range(0, 4)) begin
        if (win_d) begin d_address = AW'($urandom); d_wdata = rand_line(); end
        else i_address = AW'($urandom);
        tick();
        n_checks++; if ({l2_address, i_resp, d_resp} !== {exp_addr, 2'b00}) begin n_fail++; $display("FAIL rnd_wait it=%0d got=%h/%b exp=%h/00", it, l2_address, {i_resp, d_resp}, exp_addr); end
      end
      rd = rand_line(); l2_rdata = rd; l2_resp = 1;
      #1;
      n_checks++; if ({i_resp, d_resp} !== {!win_d, win_d}) begin n_fail++; $display("FAIL rnd_route it=%0d got=%b exp=%b", it, {i_resp, d_resp}, {!win_d, win_d}); end
      n_checks++; if ((win_d ? d_rdata : i_rdata) !== rd) begin n_fail++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, win_d ? d_rdata : i_rdata, rd); end
      tick();
      l2_resp = 0;
      if (win_d) begin pend_d = 0; d_read = 0; d_write = 0; end
      else begin pend_i = 0; i_read = 0; end
      #1;
      n_checks++; if ({busy, l2_read, l2_write, i_resp, d_resp} !== 5'b10000) begin n_fail++; $display("FAIL rnd_recover it=%0d got=%b exp=10000", it, {busy, l2_read, l2_write, i_resp, d_resp}); end
      tick();
      n_checks++; if ({busy, l2_read, l2_write} !== 3'b000) begin n_fail++; $display("FAIL rnd_back_idle it=%0d got=%b exp=000", it, {busy, l2_read, l2_write}); end
      mlast_d = win_d;
    end
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_alternation();
    test_addr_stable();
    test_reset_mid_serve();
    test_rw_conflict();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
